fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO between NUM_REQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and passes the granted beats straight onto the FIFO write port.
- It never writes while the FIFO is full.
- It also monitors the FIFO's wr_ack and overflow outputs and raises sticky error flags on protocol violations.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- FIFO_WIDTH, 16, data width; must match the FIFO.
- MAX_BURST, 4, maximum beats per grant before re-arbitration (1..15).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  producer i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  NUM_REQ  per-producer ready; at most one bit set.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  FIFO_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag (combinational from the FIFO count).
- fifo_wr_ack  in  1  FIFO write acknowledge (one cycle after an accepted write).
- fifo_overflow  in  1  FIFO overflow flag.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  high in BURST state.
- xfer_cnt  out  16  total beats written; wraps at 16'hFFFF -> 0.
- ack_err  out  1  sticky: wr_ack missing after a write.
- ovf_err  out  1  sticky: FIFO reported overflow.

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state=IDLE, grant=0, busy=0, beat_cnt=0.
  - last_grant=NUM_REQ-1, so the first winner is producer 0.
  - xfer_cnt=0, ack_err=0, ovf_err=0, wr_pend=0.
  - Reset mid-burst abandons the burst; no write occurs in the reset cycle.
- Combinational outputs:
  - req_ready and fifo_wr_en are low whenever rst=1.
- FSM has two states, IDLE and BURST.
- IDLE:
  - If any req_valid is set and fifo_full=0, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register grant=one-hot(winner), beat_cnt=0, and move to BURST.
  - The arbitration cycle costs exactly one cycle; no data moves in IDLE.
- BURST, owner g:
  - req_ready[g] = !fifo_full (combinational); all other ready bits are 0.
  - A beat transfers when req_valid[g] && req_ready[g]. In that cycle fifo_wr_en=1 and fifo_data_in=req_data slice g, with zero latency.
  - When fifo_wr_en=0, fifo_data_in=0.
  - Each transfer increments beat_cnt and xfer_cnt.
- Leaving BURST (go to IDLE, set last_grant=g, clear grant):
  - a transfer occurs with beat_cnt==MAX_BURST-1, or
  - req_valid[g]=0 in a cycle where fifo_full=0 (producer finished).
- While fifo_full=1 the FSM holds in BURST with ready low and beat_cnt unchanged, i.e. it stalls rather than releasing.
- Fairness: after a producer is released, every other requesting producer is granted before it is granted again.
- Write monitoring:
  - wr_pend <= fifo_wr_en.
  - If wr_pend=1 and fifo_wr_ack=0, set ack_err.
  - If fifo_overflow=1 at any posedge, set ovf_err.
  - Both flags clear only on rst.
- fifo_wr_en must never be 1 in a cycle where fifo_full=1.

Test Plan:
- Reset and first grant: rst high 2 cycles, then req_valid=4'b1010 held -> cycle 1 after reset in IDLE; grant=4'b0010 next cycle; 4 beats written from producer 1; then grant=4'b1000.
- Round-robin rotation: all four producers valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0. Each grant yields exactly 4 fifo_wr_en pulses and 1 idle cycle between grants; xfer_cnt=20 after 5 grants.
- Full stall:
  - Drive fifo_full=1 mid-burst after beat 2 for 3 cycles -> fifo_wr_en=0 and req_ready=0 for those 3 cycles; grant unchanged.
  - Beats 3-4 are written after full drops; no overflow.
- Early release: producer 2 drops req_valid after 1 beat, producer 3 valid -> grant returns to IDLE, last_grant=2, next grant=4'b1000.
- Monitor errors:
  - Suppress fifo_wr_ack after one write -> ack_err=1 the following cycle and it stays 1.
  - Pulse fifo_overflow one cycle -> ovf_err=1.
  - rst clears both.
- xfer_cnt wrap: preload by streaming 65536 beats -> xfer_cnt returns to 0 with no side effect on arbitration.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers in bursts of up to MAX_BURST beats.
// Beats pass through with zero latency after a one-cycle arbitration. fifo_full stalls the current owner without releasing its grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [15:0]                   xfer_cnt,
    output logic                          ack_err,
    output logic                          ovf_err
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;
    localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDXW-1:0]    r_owner;
    logic [IDXW-1:0]    r_last;
    logic [3:0]         r_beat_cnt;
    logic [15:0]        r_xfer_cnt;
    logic               r_wr_pend;
    logic               r_ack_err;
    logic               r_ovf_err;

    logic               w_in_burst;
    logic               w_owner_vld;
    logic               w_xfer;
    logic               w_any;
    logic [IDXW-1:0]    w_win;
    logic [IDXW-1:0]    w_idx;

    assign w_in_burst  = (r_state == S_BURST);
    assign w_owner_vld = req_valid[r_owner];
    assign w_xfer      = !rst && w_in_burst && w_owner_vld && !fifo_full;

    assign req_ready    = (!rst && w_in_burst && !fifo_full) ? r_grant : '0;
    assign fifo_wr_en   = w_xfer;
    assign fifo_data_in = w_xfer ? req_data[int'(r_owner)*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign grant        = r_grant;
    assign busy         = w_in_burst;
    assign xfer_cnt     = r_xfer_cnt;
    assign ack_err      = r_ack_err;
    assign ovf_err      = r_ovf_err;

    // Scan downward so the candidate closest after r_last is written last and wins.
    always_comb begin
        w_win = r_last;
        w_any = 1'b0;
        w_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = IDXW'((int'(r_last) + i) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_last     <= IDXW'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_xfer_cnt <= '0;
            r_wr_pend  <= 1'b0;
            r_ack_err  <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_wr_pend <= w_xfer;
            if (r_wr_pend && !fifo_wr_ack) r_ack_err <= 1'b1;
            if (fifo_overflow)             r_ovf_err <= 1'b1;
            if (w_xfer)                    r_xfer_cnt <= r_xfer_cnt + 16'd1;

            if (r_state == S_IDLE) begin
                if (w_any && !fifo_full) begin
                    r_state    <= S_BURST;
                    r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                    r_owner    <= w_win;
                    r_beat_cnt <= '0;
                end
            end else if (!fifo_full) begin
                // A full FIFO freezes the burst; release only on last beat or producer drop.
                if (!w_owner_vld || r_beat_cnt == BEAT_LAST) begin
                    r_state <= S_IDLE;
                    r_last  <= r_owner;
                    r_grant <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 4'd1;
                end
            end
        end
    end
endmodule
